i2c_xlate_master_seq: RTL and testbench
=======================================

// Module: i2c_xlate_master_seq
// PURPOSE
//  Single-byte I2C master sequencer that drives the master-side bus (scl/sdl) of the address translator.
//  Accepts one transaction request (7-bit address, R/W, one data byte) and generates the bus sequence:
//  START, address, ack1, data or s_data, ack2, STOP. Open-drain pins are modelled as active-low output enables.
//  Clock stretching is honoured on every SCL release.
// PARAMETERS
//  CLK_DIV     250    clk cycles per SCL quarter-period (>=2); SCL period = 4*CLK_DIV
//  TMO_CYCLES  65535  stretch-timeout limit in clk cycles (used only with I2C_SEQ_TIMEOUT_EN)
// PORTS
//  clk      in   1  system clock, rising edge
//  rst      in   1  asynchronous reset, active-high
//  req      in   1  start transaction; sampled only in IDLE
//  rw       in   1  0=write wdata, 1=read one byte
//  addr     in   7  7-bit slave address
//  wdata    in   8  write byte
//  busy     out  1  high from the cycle after req is accepted until done
//  done     out  1  one-cycle pulse at transaction end
//  ack_err  out  1  NACK seen on address or write data; valid with done, held until next accept
//  rdata    out  8  read byte; updated at end of 8th read bit
//  scl_oe   out  1  1 = pull SCL low, 0 = release
//  sdl_oe   out  1  1 = pull SDA low, 0 = release
//  scl_in   in   1  sampled SCL line (already synchronised)
//  sdl_in   in   1  sampled SDA line (already synchronised)
// BEHAVIOUR
//  - Reset (async, immediate): scl_oe=0, sdl_oe=0, busy=0, done=0, ack_err=0, rdata=0, state=IDLE.
//    Reset mid-transfer releases both lines at once; no STOP is generated.
//  - States: IDLE, START, ADDR, ACK1, DATA, ACK2, S_DATA, STOP (encoded 0..7 in that order).
//  - IDLE: req=1 with scl_in=1 and sdl_in=1 -> latch {addr,rw,wdata}; clear ack_err; busy=1 next cycle; go START.
//    req while the bus is not free or busy=1 is ignored (not queued).
//  - START: sdl_oe=1 with SCL released for 2*CLK_DIV, then scl_oe=1 -> ADDR.
//  - Bit timing, 4 quarters of CLK_DIV each:
//    Q0 SCL low, SDA updated; Q1 SCL low; Q2 SCL released; Q3 SCL high.
//    Q2 counter holds while scl_in=0 (stretch). SDA sampled on the last cycle of Q3. SDA changes only in Q0.
//  - ADDR: 8 bits {addr,rw}, MSB first -> ACK1.
//  - ACK1: SDA released; sampled 0 -> DATA (rw=0) or S_DATA (rw=1); sampled 1 -> ack_err=1 -> STOP.
//  - DATA: wdata MSB first -> ACK2; slave NACK sets ack_err=1.
//  - S_DATA: SDA released; 8 bits shifted in MSB first; rdata loaded on 8th sample.
//    ACK2 then drives NACK (SDA released).
//  - ACK2 -> STOP in all cases.
//  - STOP: Q0 sdl_oe=1 (SCL low); release SCL, wait scl_in=1, CLK_DIV cycles; release SDA; CLK_DIV cycles.
//    Then done=1 for 1 cycle; busy=0 that same cycle; -> IDLE.
//  - Write latency, no stretch: 2*CLK_DIV + 18*4*CLK_DIV + 3*CLK_DIV (+/-1) clk cycles from accept to done.
//  - A 0 written as 1 (SDA released but sampled 0) is not treated as arbitration loss; single-master bus.
//  - Bit counter is 3 bits and wraps 7->0 at each byte boundary.
// CONFIGURATION
//  I2C_SEQ_TIMEOUT_EN defined:
//    - A 16-bit counter runs while waiting in Q2 or in STOP for scl_in=1.
//    - Reaching TMO_CYCLES releases both lines, sets ack_err=1, and pulses done -> IDLE (no STOP).
//    - The counter clears on every successful SCL rise.
//  Not defined: waits indefinitely; no counter logic synthesised.
// TESTING (CLK_DIV=4 for sim)
//  1. Write, addr=0x50, wdata=0xA5, slave ACKs both -> SDA bytes 0xA0, 0xA5; STOP; done pulse; ack_err=0;
//     busy high for the write-latency window.
//  2. Write to addr=0x22, slave NACKs address -> ack_err=1; no data bits clocked; STOP follows ACK1; done pulse.
//  3. Read, addr=0x51, slave returns 0x3C -> address byte 0xA3; rdata=0x3C at done; SDA released in ACK2 (NACK).
//  4. Slave holds SCL low 100 cycles in bit 3 of data -> high phase starts only after release; bytes intact; done later by ~100.
//  5. rst asserted mid-ADDR -> scl_oe=0, sdl_oe=0, busy=0 before next clk edge; next req after rst is accepted normally.
//  6. (I2C_SEQ_TIMEOUT_EN, TMO_CYCLES=50) SCL held low forever -> ack_err=1, done after 50 cycles, lines released.

Source files
------------

// File: rtl/i2c_xlate_master_seq.sv
// i2c_xlate_master_seq: single-byte I2C master sequencer for the translator's master-side bus.
// Runs START, address byte, ACK1, write or read data byte, ACK2, STOP. The pins are open drain,
// so scl_oe/sdl_oe = 1 pulls the line low. SCL stretching is honoured on every release.
// Optional feature: define I2C_SEQ_TIMEOUT_EN to abort when SCL is held low for TMO_CYCLES cycles.
module i2c_xlate_master_seq #(
    parameter int CLK_DIV    = 250,
    parameter int TMO_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl_oe,
    output logic       sdl_oe,
    input  logic       scl_in,
    input  logic       sdl_in
);
    // Wide enough for the 2*CLK_DIV START hold.
    localparam int CW = $clog2(2 * CLK_DIV);

    typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, S_DATA, STOP} state_t;

    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be at least 2");
    end
    if (TMO_CYCLES < 1 || TMO_CYCLES > 65536) begin : g_bad_tmo
        $error("TMO_CYCLES must fit the 16-bit stretch counter");
    end

    state_t        state, state_d;
    logic [1:0]    q, q_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    shreg, shreg_d;
    logic [7:0]    lat_wdata, lat_wdata_d;
    logic          lat_rw, lat_rw_d;
    logic [7:0]    rdata_d;
    logic          ack_err_d, busy_d, done_d, scl_oe_d, sdl_oe_d;
    logic          q_end, stall;
`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0]   tmo, tmo_d;
`endif

    // State and output registers; reset drops both lines immediately without a STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            q         <= 2'd0;
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            lat_wdata <= 8'd0;
            lat_rw    <= 1'b0;
            rdata     <= 8'd0;
            ack_err   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            scl_oe    <= 1'b0;
            sdl_oe    <= 1'b0;
        end else begin
            state     <= state_d;
            q         <= q_d;
            cnt       <= cnt_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            lat_wdata <= lat_wdata_d;
            lat_rw    <= lat_rw_d;
            rdata     <= rdata_d;
            ack_err   <= ack_err_d;
            busy      <= busy_d;
            done      <= done_d;
            scl_oe    <= scl_oe_d;
            sdl_oe    <= sdl_oe_d;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    // Stretch timeout counter: counts stalled cycles, clears once SCL is seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo <= 16'd0;
        else     tmo <= tmo_d;
    end
`endif

    // Next-state, quarter-period sequencing and next line drive.
    always_comb begin
        state_d     = state;
        q_d         = q;
        cnt_d       = cnt;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;
        lat_wdata_d = lat_wdata;
        lat_rw_d    = lat_rw;
        rdata_d     = rdata;
        ack_err_d   = ack_err;
        busy_d      = busy;
        done_d      = 1'b0;
        sdl_oe_d    = sdl_oe;
        scl_oe_d    = 1'b0;
        stall       = 1'b0;
        q_end       = (cnt == CW'(CLK_DIV - 1));

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                // Only start on a free bus; anything else is dropped, not queued.
                if (req && scl_in && sdl_in) begin
                    state_d     = START;
                    q_d         = 2'd0;
                    cnt_d       = '0;
                    bit_cnt_d   = 3'd0;
                    shreg_d     = {addr, rw};
                    lat_rw_d    = rw;
                    lat_wdata_d = wdata;
                    ack_err_d   = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            START: begin
                if (cnt == CW'(2 * CLK_DIV - 1)) begin
                    state_d = ADDR;
                    q_d     = 2'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                // Bit states and STOP share the quarter engine. STOP skips Q1:
                // Q0 SDA low, Q2 SCL released (stretchable), Q3 SDA released.
                stall = (q == 2'd2) && !scl_in;
                if (!stall) begin
                    if (!q_end) begin
                        cnt_d = cnt + CW'(1);
                    end else begin
                        cnt_d = '0;
                        q_d   = (state == STOP && q == 2'd0) ? 2'd2 : q + 2'd1;
                        if (q == 2'd3) begin
                            case (state)
                                ADDR: begin
                                    shreg_d   = {shreg[6:0], sdl_in};
                                    bit_cnt_d = bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) state_d = ACK1;
                                end
                                ACK1: begin
                                    if (!sdl_in) begin
                                        state_d = lat_rw ? S_DATA : DATA;
                                        shreg_d = lat_wdata;
                                    end else begin
                                        ack_err_d = 1'b1;
                                        state_d   = STOP;
                                    end
                                end
                                DATA: begin
                                    shreg_d   = {shreg[6:0], sdl_in};
                                    bit_cnt_d = bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) state_d = ACK2;
                                end
                                S_DATA: begin
                                    shreg_d   = {shreg[6:0], sdl_in};
                                    bit_cnt_d = bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        rdata_d = {shreg[6:0], sdl_in};
                                        state_d = ACK2;
                                    end
                                end
                                ACK2: begin
                                    if (!lat_rw && sdl_in) ack_err_d = 1'b1;
                                    state_d = STOP;
                                end
                                default: begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                    busy_d  = 1'b0;
                                end
                            endcase
                        end
                    end
                end
            end
        endcase

`ifdef I2C_SEQ_TIMEOUT_EN
        tmo_d = stall ? tmo + 16'd1 : 16'd0;
        if (stall && tmo == 16'(TMO_CYCLES - 1)) begin
            state_d   = IDLE;
            q_d       = 2'd0;
            cnt_d     = '0;
            ack_err_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
        end
`endif

        // Lines follow the next state; SDA moves one cycle into Q0 so it never races the SCL fall.
        scl_oe_d = (state_d != IDLE) && (state_d != START) && (q_d < 2'd2);
        if (state_d == IDLE) begin
            sdl_oe_d = 1'b0;
        end else if (state_d == START) begin
            sdl_oe_d = 1'b1;
        end else if (q_d == 2'd0 && cnt_d == CW'(1)) begin
            case (state_d)
                ADDR, DATA: sdl_oe_d = ~shreg_d[7];
                STOP:       sdl_oe_d = 1'b1;
                default:    sdl_oe_d = 1'b0;
            endcase
        end else if (state_d == STOP && q_d == 2'd3) begin
            sdl_oe_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_i2c_xlate_master_seq.sv
// Bench for i2c_xlate_master_seq: behavioural I2C slave on the open-drain lines, a table of
// directed transactions, randomized transactions against a transaction-level model, and
// hand sequences for bus-busy, reset mid-transfer and SCL held low.
module tb_i2c_xlate_master_seq;
    localparam int CD  = 4;
    localparam int TMO = 50;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int ST  = 40;
`else
    localparam int ST  = 100;
`endif

    logic       clk = 1'b0, rst = 1'b1, req = 1'b0, rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy, done, ack_err, scl_oe, sdl_oe, scl_in, sdl_in;
    logic [7:0] rdata;

    // Slave knobs (driven by the test) and extra bus holders.
    logic       s_ack_addr = 1'b1, s_ack_data = 1'b1;
    logic [7:0] s_rd_byte = 8'd0;
    int         s_stretch = 0;
    logic       ext_sda_low = 1'b0, ext_scl_low = 1'b0;

    // Slave state (written only by the slave process).
    logic       s_pull = 1'b0, p_scl = 1'b1, p_sda = 1'b1;
    logic       s_in_xfer = 1'b0, s_is_read = 1'b0, s_addr_acked = 1'b0, m_ack_bit = 1'b0;
    int         s_hold = 0, s_bitn = 0, s_byte = 0, n_start = 0, n_stop = 0;
    logic [7:0] s_sh = 8'd0;
    logic [7:0] cap_q[$];

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] model_rdata = 8'd0;

    assign scl_in = ~scl_oe & (s_hold == 0) & ~ext_scl_low;
    assign sdl_in = ~sdl_oe & ~s_pull & ~ext_sda_low;

    always #5 clk = ~clk;

    i2c_xlate_master_seq #(.CLK_DIV(CD), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
        .scl_oe(scl_oe), .sdl_oe(sdl_oe), .scl_in(scl_in), .sdl_in(sdl_in)
    );

    // Behavioural slave: decodes START/STOP and SCL edges, captures bytes, acks, serves read data.
    always @(negedge clk) begin
        if (rst) begin
            s_in_xfer = 1'b0; s_pull = 1'b0; s_hold = 0; s_bitn = 0; s_byte = 0;
        end else begin
            if (s_hold > 0) s_hold = s_hold - 1;
            if (p_scl && scl_in && p_sda && !sdl_in) begin
                n_start++; s_in_xfer = 1'b1; s_bitn = 0; s_byte = 0; s_pull = 1'b0;
            end else if (p_scl && scl_in && !p_sda && sdl_in) begin
                n_stop++; s_in_xfer = 1'b0; s_pull = 1'b0;
            end else if (s_in_xfer && !p_scl && scl_in) begin
                if (s_bitn < 8) s_sh = {s_sh[6:0], sdl_in};
                else if (s_byte == 1) m_ack_bit = sdl_in;
                s_bitn++;
            end else if (s_in_xfer && p_scl && !scl_in) begin
                if (s_bitn == 8) begin
                    cap_q.push_back(s_sh);
                    if (s_byte == 0) begin
                        s_is_read = s_sh[0]; s_addr_acked = s_ack_addr; s_pull = s_ack_addr;
                    end else begin
                        s_pull = !s_is_read && s_ack_data;
                    end
                end else if (s_bitn == 9) begin
                    s_bitn = 0; s_byte++;
                    s_pull = s_is_read && s_addr_acked && s_byte == 1 && !s_rd_byte[7];
                end else begin
                    s_pull = s_is_read && s_addr_acked && s_byte == 1 && s_bitn > 0 && !s_rd_byte[7 - s_bitn];
                    if (s_byte == 1 && s_bitn == 3 && s_stretch > 0) s_hold = s_stretch;
                end
            end
        end
        p_scl = scl_in;
        p_sda = sdl_in;
    end

    typedef struct {
        logic [6:0] a; logic r; logic [7:0] wd; logic aa, ad; logic [7:0] rb; int st; int xreq;
        logic e_err; logic [7:0] e_rdata; int e_nb; logic [7:0] e_b0, e_b1; int e_lat;
    } vec_t;

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic check_win(input string nm, input int got, input int lo, input int hi);
        n_cmp++;
        if (got < lo || got > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
        end
    endtask

    // Issue one request, count busy cycles up to done, then check the outcome against v.
    task automatic run_and_check(input vec_t v, input string tag);
        int lat, nb0, ns0, nst0, tol;
        bit got;
        s_ack_addr = v.aa; s_ack_data = v.ad; s_rd_byte = v.rb; s_stretch = v.st;
        nb0 = cap_q.size(); ns0 = n_stop; nst0 = n_start;
        @(posedge clk); #1;
        req = 1'b1; addr = v.a; rw = v.r; wdata = v.wd;
        @(posedge clk); #1;
        req = 1'b0; addr = 7'($urandom); rw = ~v.r; wdata = 8'($urandom);
        lat = 0; got = 1'b0;
        for (int i = 1; i < 4000 && !got; i++) begin
            @(negedge clk);
            req = (i == v.xreq);
            if (req) begin addr = 7'h7F; rw = 1'b1; end
            if (busy) lat++;
            if (done) got = 1'b1;
        end
        req = 1'b0;
        tol = (v.st > 0) ? 2 : 1;
        check({tag, ".done"}, int'(got), 1);
        check({tag, ".busy_at_done"}, int'(busy), 0);
        check({tag, ".ack_err"}, int'(ack_err), int'(v.e_err));
        check({tag, ".rdata"}, int'(rdata), int'(v.e_rdata));
        check_win({tag, ".latency"}, lat, v.e_lat - tol, v.e_lat + tol);
        check({tag, ".nbytes"}, cap_q.size() - nb0, v.e_nb);
        check({tag, ".byte0"}, (cap_q.size() > nb0) ? int'(cap_q[nb0]) : -1, int'(v.e_b0));
        if (v.e_nb > 1)
            check({tag, ".byte1"}, (cap_q.size() > nb0 + 1) ? int'(cap_q[nb0 + 1]) : -1, int'(v.e_b1));
        if (v.r && v.aa) check({tag, ".master_nack"}, int'(m_ack_bit), 1);
        check({tag, ".starts"}, n_start - nst0, 1);
        check({tag, ".stops"}, n_stop - ns0, 1);
        @(negedge clk);
        check({tag, ".done_pulse"}, int'(done), 0);
        check({tag, ".lines_free"}, int'({scl_oe, sdl_oe}), 0);
        repeat (3) @(negedge clk);
        check({tag, ".no_queue"}, int'(busy), 0);
    endtask

    // Transaction-level expectation: byte list, NACK outcome and bit count from the bus rules.
    function automatic vec_t model(input logic [6:0] a, input logic r, input logic [7:0] wd,
                                   input logic aa, input logic ad, input logic [7:0] rb);
        vec_t v;
        int bits;
        v.a = a; v.r = r; v.wd = wd; v.aa = aa; v.ad = ad; v.rb = rb; v.st = 0; v.xreq = 0;
        v.e_err = !aa || (!r && !ad);
        v.e_nb  = aa ? 2 : 1;
        v.e_b0  = {a, r};
        v.e_b1  = r ? rb : wd;
        bits    = aa ? 18 : 9;
        v.e_lat = (2 + 4 * bits + 3) * CD;
        if (r && aa) model_rdata = rb;
        v.e_rdata = model_rdata;
        return v;
    endfunction

    vec_t tbl[5];

    initial begin
        int lat;
        bit got;
        //        a      r     wd     aa    ad    rb     st  xreq err   rdata  nb b0     b1     lat
        tbl[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0,  0,   1'b0, 8'h00, 2, 8'hA0, 8'hA5, 308};
        tbl[1] = '{7'h22, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00, 0,  0,   1'b1, 8'h00, 1, 8'h44, 8'h00, 164};
        tbl[2] = '{7'h51, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 0,  0,   1'b0, 8'h3C, 2, 8'hA3, 8'h3C, 308};
        tbl[3] = '{7'h50, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, ST, 0,   1'b0, 8'h3C, 2, 8'hA0, 8'h5A, 308 + ST - 2 * CD};
        tbl[4] = '{7'h10, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 0,  30,  1'b1, 8'h3C, 2, 8'h20, 8'hFF, 308};

        repeat (3) @(negedge clk);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.ack_err", int'(ack_err), 0);
        check("rst.rdata", int'(rdata), 0);
        check("rst.scl_oe", int'(scl_oe), 0);
        check("rst.sdl_oe", int'(sdl_oe), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_and_check(tbl[i], $sformatf("tbl%0d", i));
        model_rdata = 8'h3C;

        // Request while SDA is held low by someone else must be dropped.
        ext_sda_low = 1'b1;
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        repeat (4) @(negedge clk);
        check("busfree.busy", int'(busy), 0);
        ext_sda_low = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v = model(7'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 3) != 0), 8'($urandom));
            run_and_check(v, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of the address byte: lines drop before the next clock edge.
        @(posedge clk); #1 req = 1'b1; addr = 7'h5A; rw = 1'b0; wdata = 8'h11;
        @(posedge clk); #1 req = 1'b0;
        repeat (2 * CD + 6) @(posedge clk);
        @(negedge clk);
        check("midrst.busy_before", int'(busy), 1);
        rst = 1'b1; #1;
        check("midrst.scl_oe", int'(scl_oe), 0);
        check("midrst.sdl_oe", int'(sdl_oe), 0);
        check("midrst.busy", int'(busy), 0);
        @(negedge clk); rst = 1'b0;
        model_rdata = 8'h00;
        repeat (2) @(negedge clk);
        run_and_check(model(7'h33, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00), "after_rst");

        // SCL held low by the bus from the start of the transfer.
        @(posedge clk); #1 req = 1'b1; addr = 7'h40; rw = 1'b0;
        @(posedge clk); #1 req = 1'b0; ext_scl_low = 1'b1;
        lat = 0; got = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (busy) lat++;
            if (done) got = 1'b1;
        end
        check("tmo.done", int'(got), 1);
        check_win("tmo.latency", lat, 4 * CD + TMO - 2, 4 * CD + TMO + 2);
        check("tmo.ack_err", int'(ack_err), 1);
        check("tmo.lines_free", int'({scl_oe, sdl_oe}), 0);
        ext_scl_low = 1'b0;
`else
        repeat (200) @(negedge clk);
        check("hold.busy", int'(busy), 1);
        check("hold.scl_released", int'(scl_oe), 0);
        ext_scl_low = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("hold.done", int'(got), 1);
        check("hold.ack_err", int'(ack_err), 1);
`endif
        repeat (4) @(negedge clk);
        check("end.lines_free", int'({scl_oe, sdl_oe}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
